// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory (8-bit address, 16-bit data).
// Alternates ports under contention with bounded bursts and steers read data back to the requester.
module mem_port_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk_50MHz,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [7:0]  addr0,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    input  logic [15:0] mem_q,
    output logic [1:0]  owner
);

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } port_req_t;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;
    localparam logic [7:0] CNT_MAX = 8'(BURST_MAX - 1);

    logic [1:0] state, state_nxt, other_state;
    logic       last;
    logic [7:0] cnt;
    logic       owning, own_port, other_req, grant;
    port_req_t  pr [2];
    port_req_t  cur;

    assign pr[0] = {req0, we0, addr0, wdata0};
    assign pr[1] = {req1, we1, addr1, wdata1};

    // OWN1 is the only owning state with bit 1 set, so it doubles as the port index
    assign own_port    = state[1];
    assign owning      = (state == OWN0) || (state == OWN1);
    assign cur         = pr[own_port];
    assign other_req   = own_port ? req0 : req1;
    assign other_state = own_port ? OWN0 : OWN1;
    assign grant       = owning & cur.req;

    assign gnt0 = (state == OWN0) & req0;
    assign gnt1 = (state == OWN1) & req1;

    assign mem_addr = owning ? cur.addr  : 8'd0;
    assign mem_data = owning ? cur.wdata : 16'd0;
    assign mem_wren = grant & cur.we;

    assign rdata0 = mem_q;
    assign rdata1 = mem_q;
    assign owner  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                // a dropped request hands over without a grant; a saturated burst yields after its access
                if (!cur.req)
                    state_nxt = other_req ? other_state : IDLE;
                else if (other_req && cnt == CNT_MAX)
                    state_nxt = other_state;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= 8'd0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (state_nxt != state) begin
                cnt <= 8'd0;
                if (state_nxt != IDLE)
                    last <= state_nxt[1];
            end else if (grant && cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random masters, checked cycle by cycle
// against a tenure-counting reference model and a shadow copy of the memory.
module tb_mem_port_arbiter;

    localparam int BURST = 4;

    logic        clk_50MHz = 1'b0;
    logic        reset_n;
    logic        req [2];
    logic        we [2];
    logic [7:0]  addr [2];
    logic [15:0] wdata [2];
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
    logic [15:0] rdata0, rdata1, mem_data, mem_q;
    logic [7:0]  mem_addr;
    logic [1:0]  owner;

    // memory macro with preload port used only while reset is held
    logic [15:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    int passed = 0;
    int total  = 0;

    // reference model state
    int          m_own;
    int          m_ten;
    int          m_last;
    bit          m_rv [2];
    logic [15:0] m_rd;
    logic [15:0] ref_mem [256];
    bit          g_exp [2];
    bit          hit;

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_wren)
            mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    mem_port_arbiter #(.BURST_MAX(BURST)) dut (
        .clk_50MHz(clk_50MHz), .reset_n(reset_n),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_own = -1; m_ten = 0; m_last = 1;
        m_rv[0] = 0; m_rv[1] = 0;
    endtask

    task automatic new_req(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = 8'($urandom_range(0, 15));
        wdata[p] = 16'($urandom);
    endtask

    // compare every output with the model for the inputs currently applied
    task automatic check_now();
        logic [1:0]  oc;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        ew;
        #1;
        g_exp[0] = (m_own == 0) && req[0];
        g_exp[1] = (m_own == 1) && req[1];
        oc = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
        ea = 8'd0; ed = 16'd0; ew = 1'b0;
        if (m_own >= 0) begin
            ea = addr[m_own];
            ed = wdata[m_own];
            ew = req[m_own] && we[m_own];
        end
        chk("gnt0", gnt0, g_exp[0]);
        chk("gnt1", gnt1, g_exp[1]);
        chk("owner", owner, oc);
        chk("mem_addr", mem_addr, ea);
        chk("mem_data", mem_data, ed);
        chk("mem_wren", mem_wren, ew);
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        if (m_rv[0]) chk("rdata0", rdata0, m_rd);
        if (m_rv[1]) chk("rdata1", rdata1, m_rd);
    endtask

    // apply the arbitration rules to the model, then take the clock edge
    task automatic advance();
        int nxt, o;
        m_rv[0] = 0; m_rv[1] = 0;
        for (int p = 0; p < 2; p++) begin
            if (g_exp[p]) begin
                if (we[p]) ref_mem[addr[p]] = wdata[p];
                else begin m_rv[p] = 1; m_rd = ref_mem[addr[p]]; end
            end
        end
        if (m_own < 0) begin
            if (req[0] && req[1]) nxt = (m_last == 0) ? 1 : 0;
            else if (req[0])      nxt = 0;
            else if (req[1])      nxt = 1;
            else                  nxt = -1;
        end else begin
            o = 1 - m_own;
            if (!req[m_own])                       nxt = req[o] ? o : -1;
            else if (req[o] && m_ten >= BURST - 1) nxt = o;
            else                                   nxt = m_own;
        end
        if (nxt != m_own) begin
            m_ten = 0;
            if (nxt >= 0) m_last = nxt;
        end else if (nxt >= 0 && g_exp[nxt]) begin
            m_ten++;
        end
        m_own = nxt;
        @(posedge clk_50MHz); #1;
    endtask

    task automatic cycle();
        check_now();
        advance();
    endtask

    // present one access on port p and hold it until the model says it was granted
    task automatic do_access(input int p, input logic w, input logic [7:0] a, input logic [15:0] d);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            check_now();
            if (g_exp[p]) begin
                hit = 1;
                chk("acc_wren", mem_wren, w);
                chk("acc_addr", mem_addr, a);
            end
            advance();
        end
        chk("acc_granted", hit, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        pl_en = 1'b1; pl_addr = 8'd0; pl_data = 16'd0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 8'd0; wdata[p] = 16'd0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        ref_mem[8'h10] = 16'hBEEF;
        for (int i = 0; i < 256; i++) begin
            pl_addr = 8'(i); pl_data = ref_mem[i];
            @(posedge clk_50MHz); #1;
        end
        pl_en = 1'b0;
        model_reset();

        // reset state
        chk("rst_owner", owner, 2'b00);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        reset_n = 1'b1;

        // port 0 reads 0x10
        do_access(0, 1'b0, 8'h10, 16'h0);
        chk("t1_owner", owner, 2'b01);
        chk("t1_rvalid0", rvalid0, 1);
        chk("t1_rdata0", rdata0, 16'hBEEF);
        chk("t1_rvalid1", rvalid1, 0);
        req[0] = 1'b0;

        // port 1 writes 0x1234 to 0x20 and reads it back
        do_access(1, 1'b1, 8'h20, 16'h1234);
        chk("t2_wr_rvalid1", rvalid1, 0);
        do_access(1, 1'b0, 8'h20, 16'h0);
        chk("t2_rvalid1", rvalid1, 1);
        chk("t2_rdata1", rdata1, 16'h1234);
        chk("t2_rvalid0", rvalid0, 0);
        req[1] = 1'b0;
        cycle();

        // continuous contention: bursts of BURST alternating, no dead cycles
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b1; we[p] = 1'b0; addr[p] = 8'($urandom);
        end
        cycle();
        for (int k = 0; k < 16; k++) begin
            check_now();
            chk("burst_g0", gnt0, ((k / BURST) % 2) == 0);
            chk("burst_g1", gnt1, ((k / BURST) % 2) == 1);
            advance();
            for (int p = 0; p < 2; p++) if (g_exp[p]) addr[p] = 8'($urandom);
        end
        req[0] = 1'b0; req[1] = 1'b0;
        cycle();

        // long uncontended tenure, then immediate pre-emption at saturation
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'($urandom);
        cycle();
        for (int k = 0; k < 20; k++) begin
            check_now();
            chk("solo_gnt0", gnt0, 1);
            advance();
            addr[0] = 8'($urandom);
        end
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'($urandom);
        check_now();
        chk("preempt_last_g0", gnt0, 1);
        advance();
        check_now();
        chk("preempt_g1", gnt1, 1);
        chk("preempt_g0", gnt0, 0);
        advance();
        req[0] = 1'b0; req[1] = 1'b0;
        cycle();

        // reset in OWN1 with a read in flight
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h20;
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_owner", owner, 2'b00);
        chk("mid_rst_gnt1", gnt1, 0);
        chk("mid_rst_rvalid1", rvalid1, 0);
        chk("mid_rst_wren", mem_wren, 0);
        chk("mid_rst_addr", mem_addr, 0);
        model_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h05;
        @(posedge clk_50MHz); #1;
        reset_n = 1'b1;
        cycle();
        check_now();
        chk("post_rst_g0", gnt0, 1);
        chk("post_rst_g1", gnt1, 0);
        advance();
        req[0] = 1'b0; req[1] = 1'b0;
        cycle();

        // req0 drops while port 1 waits: dead cycle with no write, then OWN1
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h30; wdata[0] = 16'hA5A5;
        cycle();
        cycle();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h30;
        cycle();
        req[0] = 1'b0;
        check_now();
        chk("drop_owner", owner, 2'b01);
        chk("drop_gnt0", gnt0, 0);
        chk("drop_gnt1", gnt1, 0);
        chk("drop_wren", mem_wren, 0);
        advance();
        check_now();
        chk("handover_owner", owner, 2'b10);
        chk("handover_gnt1", gnt1, 1);
        advance();
        chk("handover_rdata1", rdata1, 16'hA5A5);
        req[1] = 1'b0;
        cycle();

        // random masters that hold each request until granted
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++)
                if (!req[p] && $urandom_range(0, 2) == 0) new_req(p);
            cycle();
            for (int p = 0; p < 2; p++)
                if (g_exp[p]) begin
                    if ($urandom_range(0, 3) != 0) new_req(p);
                    else req[p] = 1'b0;
                end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
